// File: rtl/apb_master_bridge.sv
// Bridges a single-request core memory port onto an APB3 master port.
// One SETUP + ACCESS per request, PREADY wait states, optional ACCESS watchdog.
module apb_master_bridge #(
   parameter int unsigned BUS_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] S_MEM_ADDR,
   input  logic [BUS_WIDTH-1:0] S_MEM_IN,
   input  logic                 S_MEM_WE,
   input  logic                 S_REQ,
   output logic [BUS_WIDTH-1:0] S_MEM_OUT,
   output logic                 S_ACK,
   output logic                 S_MEM_BUSY,
   output logic                 S_ERR,
   output logic [BUS_WIDTH-1:0] M_PADDR,
   output logic                 M_PWRITE,
   output logic                 M_PSELx,
   output logic                 M_PENABLE,
   output logic [BUS_WIDTH-1:0] M_PWDATA,
   input  logic [BUS_WIDTH-1:0] M_PRDATA,
   input  logic                 M_PREADY
);

   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [BUS_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
   logic                 we_q, we_d;
   logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic                 ack_q, ack_d;
   logic                 busy_q, busy_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register cleanly
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (S_REQ) begin
               addr_d  = S_MEM_ADDR;
               wdata_d = S_MEM_IN;
               we_d    = S_MEM_WE;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A PREADY in the watchdog's final cycle wins over the abort
            if (M_PREADY) begin
               if (!we_q) begin
                  rdata_d = M_PRDATA;
               end
               state_d = ST_DONE;
            end else if (WD_EN && (cnt_q == CNT_LAST)) begin
               rdata_d = '1;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (WD_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d = (state_d == ST_ACCESS);
      ack_d     = (state_d == ST_DONE);
      busy_d    = (state_d != ST_IDLE);
   end

   assign S_MEM_OUT  = rdata_q;
   assign S_ACK      = ack_q;
   assign S_ERR      = err_q;
   assign S_MEM_BUSY = busy_q;
   assign M_PADDR    = addr_q;
   assign M_PWDATA   = wdata_q;
   assign M_PWRITE   = we_q;
   assign M_PSELx    = psel_q;
   assign M_PENABLE  = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a core-side driver, an APB slave
// responder and a monitor that checks APB phases and acknowledges.
module tb_apb_master_bridge;

   localparam int unsigned BW = 16;
   localparam int TO = 4;

   logic          clk;
   logic          reset;
   logic [BW-1:0] S_MEM_ADDR, S_MEM_IN, S_MEM_OUT;
   logic          S_MEM_WE, S_REQ, S_ACK, S_MEM_BUSY, S_ERR;
   logic [BW-1:0] M_PADDR, M_PWDATA, M_PRDATA;
   logic          M_PWRITE, M_PSELx, M_PENABLE, M_PREADY;

   apb_master_bridge #(.BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .S_MEM_ADDR(S_MEM_ADDR), .S_MEM_IN(S_MEM_IN), .S_MEM_WE(S_MEM_WE), .S_REQ(S_REQ),
      .S_MEM_OUT(S_MEM_OUT), .S_ACK(S_ACK), .S_MEM_BUSY(S_MEM_BUSY), .S_ERR(S_ERR),
      .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
      .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
   );

   typedef struct { logic [BW-1:0] addr; logic [BW-1:0] wdata; logic we; } apb_t;
   typedef struct { int waits; logic [BW-1:0] prdata; } slv_t;
   typedef struct { logic err; logic [BW-1:0] data; int ack_cyc; } exp_t;

   apb_t apb_q[$];
   slv_t slv_q[$];
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [BW-1:0] last_out = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_out"}, 32'(S_MEM_OUT), 0);
      check({tag, "_ack"},     32'(S_ACK), 0);
      check({tag, "_busy"},    32'(S_MEM_BUSY), 0);
      check({tag, "_err"},     32'(S_ERR), 0);
      check({tag, "_paddr"},   32'(M_PADDR), 0);
      check({tag, "_pwdata"},  32'(M_PWDATA), 0);
      check({tag, "_pwrite"},  32'(M_PWRITE), 0);
      check({tag, "_psel"},    32'(M_PSELx), 0);
      check({tag, "_penable"}, 32'(M_PENABLE), 0);
   endtask

   // Issue one request; the expected response comes from the transfer rules alone
   task automatic do_txn(input logic we, input logic [BW-1:0] addr, input logic [BW-1:0] wdata,
                         input int waits, input logic [BW-1:0] prdata, output int ack_at);
      apb_t a;
      slv_t s;
      exp_t e;
      int   n;
      @(negedge clk);
      a.addr = addr; a.wdata = wdata; a.we = we;
      s.waits = waits; s.prdata = prdata;
      if (waits >= TO) begin
         e.err = 1'b1; e.data = '1; e.ack_cyc = cyc + 2 + TO;
      end else begin
         e.err = 1'b0; e.data = we ? last_out : prdata; e.ack_cyc = cyc + 3 + waits;
      end
      last_out = e.data;
      apb_q.push_back(a);
      slv_q.push_back(s);
      exp_q.push_back(e);
      S_MEM_ADDR = addr; S_MEM_IN = wdata; S_MEM_WE = we; S_REQ = 1'b1;
      @(negedge clk);
      S_MEM_ADDR = BW'($urandom); S_MEM_IN = BW'($urandom); S_MEM_WE = 1'($urandom);
      n = 0;
      while (!S_ACK && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!S_ACK) begin
         errors++;
         $display("FAIL ack_wait: no S_ACK within 40 cycles, got 0 expected 1 (cycle %0d)", cyc);
      end
      ack_at = cyc;
      S_REQ = 1'b0;
   endtask

   // APB slave: holds PREADY low for the planned number of ACCESS cycles
   initial begin
      slv_t cur;
      int   acc;
      cur.waits = 0; cur.prdata = '0;
      acc = 0;
      M_PREADY = 1'b0;
      M_PRDATA = '0;
      forever begin
         @(negedge clk);
         if (M_PSELx && !M_PENABLE && slv_q.size() != 0) begin
            cur = slv_q.pop_front();
         end
         if (M_PSELx && M_PENABLE) begin
            acc++;
            M_PREADY = (acc > cur.waits);
            M_PRDATA = M_PREADY ? cur.prdata : BW'($urandom);
         end else begin
            acc = 0;
            M_PREADY = 1'($urandom);
            M_PRDATA = BW'($urandom);
         end
      end
   end

   // Monitor: APB phase rules, address/data stability and acknowledge scoreboard
   initial begin
      apb_t cur;
      exp_t e;
      logic prev_setup;
      cur.addr = '0; cur.wdata = '0; cur.we = 1'b0;
      prev_setup = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_setup = 1'b0;
         end else begin
            if (M_PENABLE) check("penable_needs_psel", 32'(M_PSELx), 1);
            if (prev_setup) check("setup_one_cycle", 32'(M_PSELx && M_PENABLE), 1);
            if (M_PSELx && !M_PENABLE) begin
               if (apb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_setup: got SETUP, expected none (cycle %0d)", cyc);
               end else begin
                  cur = apb_q.pop_front();
               end
            end
            if (M_PSELx) begin
               check("paddr", 32'(M_PADDR), 32'(cur.addr));
               check("pwdata", 32'(M_PWDATA), 32'(cur.wdata));
               check("pwrite", 32'(M_PWRITE), 32'(cur.we));
               check("busy_in_xfer", 32'(S_MEM_BUSY), 1);
            end
            if (S_ACK) begin
               check("done_psel_penable", 32'({M_PSELx, M_PENABLE}), 0);
               check("busy_in_done", 32'(S_MEM_BUSY), 1);
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_ack: got S_ACK, expected none (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                  check("mem_out", 32'(S_MEM_OUT), 32'(e.data));
                  check("err", 32'(S_ERR), 32'(e.err));
               end
            end else begin
               check("err_without_ack", 32'(S_ERR), 0);
            end
            prev_setup = M_PSELx && !M_PENABLE;
         end
      end
   end

   initial begin
      int a0, a1;
      apb_t a;
      slv_t s;
      reset = 1'b0;
      S_REQ = 1'b0; S_MEM_WE = 1'b0; S_MEM_ADDR = '0; S_MEM_IN = '0;
      #1;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      reset = 1'b1;

      do_txn(1'b1, 16'h0090, 16'h1234, 0, 16'h5555, a0);   // zero-wait write
      do_txn(1'b0, 16'h00A3, 16'h0000, 3, 16'hBEEF, a0);   // three wait states
      do_txn(1'b0, 16'h0011, 16'h0000, TO, 16'h7777, a0);  // watchdog abort
      do_txn(1'b0, 16'h0022, 16'h0000, TO - 1, 16'h0042, a0); // PREADY on last cycle

      // Reset asserted in the ACCESS phase of a read
      @(negedge clk);
      a.addr = 16'h00C4; a.wdata = 16'h0000; a.we = 1'b0;
      s.waits = 3; s.prdata = 16'hDEAD;
      apb_q.push_back(a);
      slv_q.push_back(s);
      S_MEM_ADDR = a.addr; S_MEM_IN = a.wdata; S_MEM_WE = 1'b0; S_REQ = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_penable", 32'(M_PENABLE), 1);
      #2 reset = 1'b0;
      #1 check_reset_outputs("mid_reset");
      S_REQ = 1'b0;
      last_out = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("held_reset");
      reset = 1'b1;
      do_txn(1'b0, 16'h0101, 16'h0000, 0, 16'h3C3C, a0);

      // Back-to-back: request dropped only for the IDLE cycle
      do_txn(1'b1, 16'h0200, 16'hA5A5, 0, 16'h0000, a0);
      do_txn(1'b1, 16'h0202, 16'h5A5A, 0, 16'h0000, a1);
      check("b2b_ack_spacing", 32'(a1 - a0), 4);

      for (int i = 0; i < 60; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         do_txn(1'($urandom), BW'($urandom), BW'($urandom), $urandom_range(0, TO + 1),
                BW'($urandom), a0);
      end

      repeat (6) @(negedge clk);
      check("pending_acks", 32'(exp_q.size()), 0);
      check("pending_setups", 32'(apb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts the core's single-request memory interface into APB3 transactions toward the APB interconnect; it is the stage directly upstream of the interconnect and drives its slave-side port. Each accepted request becomes one SETUP plus ACCESS sequence, with wait states driven by PREADY. A cycle-count watchdog aborts transfers that never complete. Results return to the core as a one-cycle acknowledge with read data.

## Interface
- BUS_WIDTH, 16, address and data width
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; 0 disables the watchdog
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- S_MEM_ADDR  in  BUS_WIDTH  request address
- S_MEM_IN  in  BUS_WIDTH  write data
- S_MEM_WE  in  1  1 = write, 0 = read
- S_REQ  in  1  request, level; held by the core until S_ACK
- S_MEM_OUT  out  BUS_WIDTH  read data, registered, valid when S_ACK=1
- S_ACK  out  1  one-cycle completion pulse
- S_MEM_BUSY  out  1  high whenever state is not IDLE
- S_ERR  out  1  pulses together with S_ACK on a watchdog abort
- M_PADDR  out  BUS_WIDTH  APB address
- M_PWRITE  out  1  APB direction
- M_PSELx  out  1  APB select, to the interconnect
- M_PENABLE  out  1  APB enable
- M_PWDATA  out  BUS_WIDTH  APB write data
- M_PRDATA  in  BUS_WIDTH  APB read data
- M_PREADY  in  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE.** PSELx=0, PENABLE=0, BUSY=0.
  - If S_REQ=1, capture ADDR, IN and WE into address, write-data and direction registers, then go to SETUP.
- **SETUP.** PSELx=1, PENABLE=0. M_PADDR, M_PWDATA and M_PWRITE come from the capture registers. Go to ACCESS unconditionally. Clear the watchdog counter.
- **ACCESS.** PSELx=1, PENABLE=1, address, data and direction unchanged.
  - If PREADY=1 and this is a read, load M_PRDATA into S_MEM_OUT.
  - If PREADY=1 and this is a write, S_MEM_OUT keeps its previous value.
  - If PREADY=1, go to DONE.
  - If PREADY=0, increment the watchdog counter.
  - If TIMEOUT_CYCLES≠0, PREADY=0 and the counter equals TIMEOUT_CYCLES−1, abort: load S_MEM_OUT with all ones, set the error flag, go to DONE.
- **DONE.** S_ACK=1 and S_ERR=error flag, for this cycle only. PSELx=0, PENABLE=0. S_REQ is not sampled. Go to IDLE and clear the error flag.
- M_PADDR, M_PWDATA and M_PWRITE hold their last captured values in IDLE and DONE.
- Watchdog counter width is the bits needed to hold TIMEOUT_CYCLES. It never wraps, because the abort fires first.
- PREADY=1 in the same cycle the watchdog would fire: the transfer completes normally and S_ERR=0.
- Changes on the S_* inputs after capture do not affect the APB transfer in flight.

## Timing
- Reset values (reset=0):
  - All outputs 0, including M_PADDR, M_PWDATA and S_MEM_OUT.
  - State IDLE, counter 0, error flag 0.
- Reset asserted mid-transaction: all outputs go to reset values asynchronously. The transfer is abandoned with no S_ACK. Deassertion is synchronous to clk.
- Latency: S_REQ sampled high at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → S_ACK in cycle 3 if PREADY=1 in cycle 2.
  - Minimum: 3 cycles from request to acknowledge.
  - Each wait state (PREADY=0 in ACCESS) adds one cycle.
- Throughput: back-to-back requests are accepted every 4 cycles, because DONE is followed by one IDLE cycle in which S_REQ is re-sampled.
- The core must drop S_REQ at the edge that ends DONE, or a second identical transfer starts.
- Watchdog: ACCESS lasts at most TIMEOUT_CYCLES cycles. An abort gives S_ACK and S_ERR in cycle 2+TIMEOUT_CYCLES.
- APB compliance:
  - PENABLE is never 1 without PSELx.
  - The SETUP phase is exactly one cycle.
  - PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.

## Test plan
- **Zero-wait write.** REQ, WE=1, ADDR=0x0090, IN=0x1234, PREADY=1.
  - SETUP in cycle 1 with PADDR=0x0090, PWDATA=0x1234, PWRITE=1.
  - PENABLE in cycle 2, S_ACK in cycle 3, S_ERR=0.
  - S_MEM_OUT unchanged.
- **Read with 3 wait states.** WE=0, ADDR=0x00A3, PREADY low for 3 ACCESS cycles, then high with PRDATA=0xBEEF.
  - S_ACK in cycle 6, S_MEM_OUT=0xBEEF.
  - PSELx, PENABLE and PADDR stable throughout.
- **Timeout.** TIMEOUT_CYCLES=4, PREADY held 0.
  - ACCESS lasts 4 cycles.
  - S_ACK=S_ERR=1 in cycle 6, S_MEM_OUT=0xFFFF.
  - PSELx=0 in DONE.
- **Timeout tie.** TIMEOUT_CYCLES=4, PREADY rises in the 4th ACCESS cycle with PRDATA=0x0042.
  - Normal completion, S_ERR=0, S_MEM_OUT=0x0042.
- **Reset mid-ACCESS.** Assert reset during ACCESS of a read.
  - All outputs 0 immediately, no S_ACK.
  - After release, a new read completes with the minimum 3-cycle latency.
- **Back-to-back.** Two requests, REQ dropped for exactly the IDLE cycle, with S_MEM_IN changed after capture.
  - Two complete APB transfers, ACKs 4 cycles apart.
  - The first transfer's PWDATA equals the captured value.
